// File: rtl/ifu_if.sv
// Fetch-side bus bundle: instruction memory read channel, decode output
// channel and the execute-stage redirect request.
interface ifu_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        out_valid;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // IFU side
    modport master (
        output araddr, arvalid, rready,
        output inst, inst_pc, inst_fault, out_valid,
        input  arready, rdata, rresp, rvalid,
        input  out_ready, redirect_valid, redirect_pc
    );

    // Memory / decode / execute side
    modport slave (
        input  araddr, arvalid, rready,
        input  inst, inst_pc, inst_fault, out_valid,
        output arready, rdata, rresp, rvalid,
        output out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding read at a time, holds the fetched
// word until decode accepts it, and follows execute-stage redirects.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic   clk,
    input  logic   reset,
    ifu_if.master  bus
);

    typedef enum logic [1:0] {IDLE, AR, R, OUT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_fault_q, inst_fault_d;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = bus.redirect_pc & ~32'h3;

    // State and datapath registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pending_pc_q <= '0;
            discard_q    <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            discard_q    <= discard_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    // Next-state logic: issue, wait for response, present, follow redirects
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        discard_d    = discard_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        case (state_q)
            IDLE: state_d = AR;
            AR: begin
                // The issued request cannot be withdrawn; remember the
                // redirect and drop the response once it returns.
                if (bus.redirect_valid) begin
                    pending_pc_d = redirect_tgt;
                    discard_d    = 1'b1;
                end
                if (bus.arready) state_d = R;
            end
            R: begin
                if (bus.redirect_valid) begin
                    pending_pc_d = redirect_tgt;
                    discard_d    = 1'b1;
                end
                if (bus.rvalid) begin
                    if (discard_q || bus.redirect_valid) begin
                        // A redirect arriving together with the response wins
                        discard_d = 1'b0;
                        pc_d      = bus.redirect_valid ? redirect_tgt : pending_pc_q;
                        state_d   = AR;
                    end else begin
                        inst_fault_d = (bus.rresp != 2'b00);
                        inst_d       = (bus.rresp != 2'b00) ? '0 : bus.rdata;
                        inst_pc_d    = pc_q;
                        state_d      = OUT;
                    end
                end
            end
            OUT: begin
                if (bus.redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = AR;
                end else if (bus.out_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = AR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.araddr     = pc_q;
    assign bus.arvalid    = (state_q == AR);
    assign bus.rready     = (state_q == R);
    assign bus.out_valid  = (state_q == OUT);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_fault = inst_fault_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: transaction-level fetch model plus directed
// scenarios with hand-computed expectations.
module tb_ifu;
    localparam logic [31:0] RST_PC = 32'h80000000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ifu_if bus();

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic        chk_en      = 1'b0;
    logic        auto_mode   = 1'b1;
    logic        auto_rvalid = 1'b0;
    logic [31:0] auto_rdata  = '0;
    logic [1:0]  auto_rresp  = '0;
    logic        man_rvalid  = 1'b0;
    logic [31:0] man_rdata   = '0;
    logic [31:0] fault_addr  = 32'h80000010;
    logic [31:0] last_req_addr = '0;

    assign bus.rvalid = auto_mode ? auto_rvalid : man_rvalid;
    assign bus.rdata  = auto_mode ? auto_rdata  : man_rdata;
    assign bus.rresp  = auto_mode ? auto_rresp  : 2'b00;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endfunction

    // Zero-wait memory: answers in the cycle after the address handshake
    always @(negedge clk) begin
        auto_rvalid = bus.rready;
        auto_rdata  = last_req_addr ^ 32'h13;
        auto_rresp  = (last_req_addr == fault_addr) ? 2'b10 : 2'b00;
    end

    // Transaction-level model of the fetch stream
    logic        m_has_out, m_stale, m_out_fault;
    logic [31:0] m_next, m_target, m_req_addr, m_out_pc, m_out_inst, tgt;
    logic        prev_ar, prev_ov;
    int          ar_rise_q[$];
    int          ov_rise_q[$];
    int          hs_cyc_q[$];
    logic [31:0] hs_pc_q[$];
    logic [31:0] hs_inst_q[$];

    always @(posedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_has_out});
            if (m_has_out) begin
                chk("inst_pc", bus.inst_pc, m_out_pc);
                chk("inst", bus.inst, m_out_inst);
                chk("inst_fault", {31'b0, bus.inst_fault}, {31'b0, m_out_fault});
            end
            if (bus.arvalid) chk("araddr", bus.araddr, m_next);
        end
        if (reset) begin
            m_has_out = 1'b0;
            m_stale   = 1'b0;
            m_next    = RST_PC;
        end else if (chk_en) begin
            if (bus.arvalid && !prev_ar) ar_rise_q.push_back(cyc);
            if (bus.out_valid && !prev_ov) ov_rise_q.push_back(cyc);
            if (bus.redirect_valid) begin
                tgt = bus.redirect_pc & ~32'h3;
                if (bus.out_valid) begin
                    m_has_out = 1'b0;
                    m_next    = tgt;
                end else if (bus.arvalid || bus.rready) begin
                    m_stale  = 1'b1;
                    m_target = tgt;
                end
            end else if (bus.out_valid && bus.out_ready) begin
                m_has_out = 1'b0;
                m_next    = m_out_pc + 32'd4;
                hs_cyc_q.push_back(cyc);
                hs_pc_q.push_back(m_out_pc);
                hs_inst_q.push_back(m_out_inst);
            end
            if (bus.rvalid && bus.rready) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_next  = m_target;
                end else begin
                    m_has_out   = 1'b1;
                    m_out_pc    = m_req_addr;
                    m_out_fault = (bus.rresp != 2'b00);
                    m_out_inst  = (bus.rresp != 2'b00) ? 32'h0 : bus.rdata;
                end
            end
            if (bus.arvalid && bus.arready) begin
                m_req_addr    = bus.araddr;
                last_req_addr = bus.araddr;
            end
        end
        prev_ar = bus.arvalid;
        prev_ov = bus.out_valid;
    end

    task automatic wait_ov(input string name);
        int k = 0;
        while (bus.out_valid !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'b0, bus.out_valid}, 32'd1);
    endtask

    task automatic wait_rready(input string name);
        int k = 0;
        while (bus.rready !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'b0, bus.rready}, 32'd1);
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_arvalid"}, {31'b0, bus.arvalid}, 32'd0);
        chk({name, "_rready"}, {31'b0, bus.rready}, 32'd0);
        chk({name, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({name, "_inst"}, bus.inst, 32'd0);
        chk({name, "_inst_pc"}, bus.inst_pc, 32'd0);
        chk({name, "_inst_fault"}, {31'b0, bus.inst_fault}, 32'd0);
    endtask

    initial begin
        logic [31:0] held_pc, held_inst;
        int k;
        bus.arready        = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        chk_en = 1'b1;
        reset  = 1'b0;

        // Straight line
        k = 0;
        while (hs_pc_q.size() < 3 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("line_count", 32'(hs_pc_q.size()), 32'd3);
        if (hs_pc_q.size() >= 3) begin
            chk("line_pc0", hs_pc_q[0], 32'h80000000);
            chk("line_inst0", hs_inst_q[0], 32'h80000013);
            chk("line_pc1", hs_pc_q[1], 32'h80000004);
            chk("line_pc2", hs_pc_q[2], 32'h80000008);
            chk("line_gap1", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd3);
            chk("line_gap2", 32'(hs_cyc_q[2] - hs_cyc_q[1]), 32'd3);
        end
        if (ar_rise_q.size() > 0 && ov_rise_q.size() > 0)
            chk("latency", 32'(ov_rise_q[0] - ar_rise_q[0]), 32'd2);
        else
            chk("latency_seen", 32'(ov_rise_q.size()), 32'd1);

        // Backpressure
        bus.out_ready = 1'b0;
        wait_ov("bp_wait");
        held_pc   = bus.inst_pc;
        held_inst = bus.inst;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_pc", bus.inst_pc, held_pc);
            chk("bp_inst", bus.inst, held_inst);
            chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp_no_ar", {31'b0, bus.arvalid}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_ar", {31'b0, bus.arvalid}, 32'd1);
        chk("bp_next_addr", bus.araddr, held_pc + 32'd4);

        // Redirect while awaiting the response; the latest target wins
        auto_mode = 1'b0;
        wait_rready("rd_wait");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h90000000;
        @(negedge clk);
        bus.redirect_pc    = 32'h80000102;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        man_rvalid = 1'b0;
        chk("rd_no_out", {31'b0, bus.out_valid}, 32'd0);
        chk("rd_ar", {31'b0, bus.arvalid}, 32'd1);
        chk("rd_addr", bus.araddr, 32'h80000100);

        // Address stall with a redirect in its second cycle
        auto_mode   = 1'b1;
        bus.arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("st_addr", bus.araddr, 32'h80000100);
            chk("st_valid", {31'b0, bus.arvalid}, 32'd1);
            if (i == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h80000200;
            end
            if (i == 1) bus.redirect_valid = 1'b0;
        end
        bus.arready = 1'b1;
        repeat (2) @(negedge clk);
        chk("st_next_ar", {31'b0, bus.arvalid}, 32'd1);
        chk("st_next_addr", bus.araddr, 32'h80000200);

        // Redirect coinciding with an output handshake; unaligned target
        wait_ov("ov200_wait");
        chk("ov200_pc", bus.inst_pc, 32'h80000200);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80000011;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        chk("rh_out_dropped", {31'b0, bus.out_valid}, 32'd0);
        chk("rh_addr", bus.araddr, 32'h80000010);

        // Access fault
        wait_ov("flt_wait");
        chk("flt_fault", {31'b0, bus.inst_fault}, 32'd1);
        chk("flt_inst", bus.inst, 32'h0);
        chk("flt_pc", bus.inst_pc, 32'h80000010);
        @(negedge clk);
        chk("flt_next", bus.araddr, 32'h80000014);

        // PC wrap at the top of the address space
        wait_ov("wr_wait0");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFFFFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        wait_ov("wr_wait1");
        chk("wr_pc", bus.inst_pc, 32'hFFFFFFFC);
        chk("wr_inst", bus.inst, 32'hFFFFFFEF);
        @(negedge clk);
        chk("wr_next", bus.araddr, 32'h00000000);

        // Reset during the response wait, then a late response in IDLE/AR
        auto_mode = 1'b0;
        wait_rready("rst_wait");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cleared("rst_mid");
        man_rvalid  = 1'b1;
        man_rdata   = 32'h0BADBAD0;
        bus.arready = 1'b0;
        @(negedge clk);
        chk("rst_ar", {31'b0, bus.arvalid}, 32'd1);
        chk("rst_addr", bus.araddr, 32'h80000000);
        chk("rst_rready", {31'b0, bus.rready}, 32'd0);
        @(negedge clk);
        man_rvalid  = 1'b0;
        bus.arready = 1'b1;
        auto_mode   = 1'b1;
        wait_ov("rst_ov_wait");
        chk("rst_first_pc", bus.inst_pc, 32'h80000000);
        chk("rst_first_inst", bus.inst, 32'h80000013);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
